// File: rtl/sram_ctrl_if.sv
// Request/response and SRAM-side signal bundle for sram_ctrl.
// slave = controller view; master = requester plus SRAM environment view.
interface sram_ctrl_if #(
    parameter int unsigned AddressSize = 18,
    parameter int unsigned WordSize    = 8
);
    logic                   ReqValid;
    logic                   ReqReady;
    logic                   ReqWrite;
    logic [AddressSize-1:0] ReqAddr;
    logic [WordSize-1:0]    ReqWData;
    logic                   RspValid;
    logic [WordSize-1:0]    RspData;
    logic                   ErrFlag;
    logic [AddressSize-1:0] SramAddress;
    logic [WordSize-1:0]    SramInData;
    logic [WordSize-1:0]    SramOutData;
    logic                   SrambCE;
    logic                   SrambWE;

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, SramOutData,
        output ReqReady, RspValid, RspData, ErrFlag,
        output SramAddress, SramInData, SrambCE, SrambWE
    );

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, SramOutData,
        input  ReqReady, RspValid, RspData, ErrFlag,
        input  SramAddress, SramInData, SrambCE, SrambWE
    );
endinterface

// File: rtl/sram_ctrl.sv
// Valid/ready front end that sequences CE/WE strobes for an asynchronous SRAM.
// Define SRAM_CTRL_WRCHK_EN to add a read-back verify after every write (sets sticky ErrFlag).
module sram_ctrl #(
    parameter int unsigned AddressSize = 18,
    parameter int unsigned WordSize    = 8,
    parameter int unsigned WaitStates  = 1
) (
    input logic        Clk,
    input logic        Reset,
    sram_ctrl_if.slave bus
);
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] WaitLd = CntW'(WaitStates);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_VSETUP,
        S_VACCESS
    } state_t;

    state_t                 r_state;
    logic [CntW-1:0]        r_cnt;
    logic                   r_write;
    logic                   r_ready;
    logic                   r_rsp_valid;
    logic [WordSize-1:0]    r_rsp_data;
    logic [AddressSize-1:0] r_addr;
    logic [WordSize-1:0]    r_wdata;
    logic                   r_ce_n;
    logic                   r_we_n;
`ifdef SRAM_CTRL_WRCHK_EN
    logic                   r_err;
`endif

    // Every output comes straight from a flop so the SRAM strobes cannot glitch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ce_n      <= 1'b1;
            r_we_n      <= 1'b1;
`ifdef SRAM_CTRL_WRCHK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.ReqValid) begin
                        r_addr  <= bus.ReqAddr;
                        r_wdata <= bus.ReqWData;
                        r_write <= bus.ReqWrite;
                        r_ce_n  <= 1'b0;
                        r_ready <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= WaitLd;
                    r_we_n  <= ~r_write;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_HOLD;
                        if (!r_write) begin
                            r_rsp_data  <= bus.SramOutData;
                            r_rsp_valid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                S_HOLD: begin
`ifdef SRAM_CTRL_WRCHK_EN
                    if (r_write) begin
                        r_state <= S_VSETUP;
                    end else begin
                        r_ce_n  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
`else
                    r_ce_n  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
`endif
                end
`ifdef SRAM_CTRL_WRCHK_EN
                S_VSETUP: begin
                    r_cnt   <= WaitLd;
                    r_state <= S_VACCESS;
                end
                // Read-back compare against the still-latched write data.
                S_VACCESS: begin
                    if (r_cnt == '0) begin
                        if (bus.SramOutData != r_wdata) r_err <= 1'b1;
                        r_ce_n  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
`endif
                default: begin
                    r_ce_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ReqReady    = r_ready;
    assign bus.RspValid    = r_rsp_valid;
    assign bus.RspData     = r_rsp_data;
    assign bus.SramAddress = r_addr;
    assign bus.SramInData  = r_wdata;
    assign bus.SrambCE     = r_ce_n;
    assign bus.SrambWE     = r_we_n;
`ifdef SRAM_CTRL_WRCHK_EN
    assign bus.ErrFlag     = r_err;
`else
    assign bus.ErrFlag     = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 256K x 8 SRAM model.
// Strobe timing is expected per access relative to the acceptance edge.
module tb_sram_ctrl #(
    parameter int unsigned WS = 1
);
`ifdef SRAM_CTRL_WRCHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic rst;
    bit   force_bad;
    int   total;
    int   bad;
    int   cyc;
    logic [7:0] rsp_q[$];
    bit   [7:0] mem [0:262143];

    sram_ctrl_if #(.AddressSize(18), .WordSize(8)) bus ();

    sram_ctrl #(.AddressSize(18), .WordSize(8), .WaitStates(WS)) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: writes while CE and WE are low, drives data only while reading.
    always @(posedge clk) begin
        if (!bus.SrambCE && !bus.SrambWE) mem[bus.SramAddress] <= bus.SramInData;
    end
    assign bus.SramOutData = (!bus.SrambCE && bus.SrambWE) ?
                             (force_bad ? 8'h00 : mem[bus.SramAddress]) : 8'h00;

    always @(negedge clk) begin
        if (bus.RspValid) rsp_q.push_back(bus.RspData);
    end

    typedef struct {
        bit         wr;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One request, observed cycle by cycle; sample n is taken after edge E0+n.
    task automatic run_req(input bit wr, input logic [17:0] a, input logic [7:0] d,
                           input logic [7:0] exp, input string nm);
        int ce_lo = 0;
        int we_lo = 0;
        int rv_cnt = 0;
        int rv_at = -1;
        int rdy_at = -1;
        int t = 0;
        bit hold_ok = 1'b1;
        logic [7:0] rd = '0;
        @(negedge clk);
        while (!bus.ReqReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        bus.ReqValid = 1'b1;
        bus.ReqWrite = wr;
        bus.ReqAddr  = a;
        bus.ReqWData = d;
        @(posedge clk);
        @(negedge clk);
        bus.ReqValid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!bus.SrambCE) begin
                ce_lo++;
                if (bus.SramAddress !== a || (wr && bus.SramInData !== d)) hold_ok = 1'b0;
            end
            if (!bus.SrambWE) we_lo++;
            if (bus.RspValid) begin
                rv_cnt++;
                rv_at = n;
                rd    = bus.RspData;
            end
            if (bus.ReqReady) begin
                rdy_at = n;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_ce_cycles"}, ce_lo, WS + 3 + ((wr && CHK) ? WS + 2 : 0));
        chk({nm, "_we_cycles"}, we_lo, wr ? WS + 1 : 0);
        chk({nm, "_ready_at"}, rdy_at, WS + 3 + ((wr && CHK) ? WS + 2 : 0));
        chk({nm, "_addr_hold"}, 32'(hold_ok), 32'd1);
        if (wr) begin
            chk({nm, "_no_rsp"}, rv_cnt, 0);
        end else begin
            chk({nm, "_rsp_cnt"}, rv_cnt, 1);
            chk({nm, "_rsp_at"}, rv_at, WS + 2);
            chk({nm, "_rsp_data"}, 32'(rd), 32'(exp));
        end
    endtask

    initial begin
        int acc[6];
        bit wrs[6];
        logic [17:0] adrs[6];
        logic [7:0]  dats[6];
        int t;
        int ce_hi;

        total = 0;
        bad = 0;
        cyc = 0;
        force_bad = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqWData = '0;

        vecs[0] = '{1'b1, 18'h00010, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 18'h00010, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 18'h3FFFF, 8'h5A, 8'h00};
        vecs[3] = '{1'b0, 18'h3FFFF, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 18'h00000, 8'hC3, 8'h00};
        vecs[5] = '{1'b0, 18'h00000, 8'h00, 8'hC3};
        vecs[6] = '{1'b0, 18'h00010, 8'h00, 8'hA5};

        // Reset values.
        rst = 1'b1;
        #3;
        chk("rst_ready", 32'(bus.ReqReady), 32'd1);
        chk("rst_rspvalid", 32'(bus.RspValid), 32'd0);
        chk("rst_rspdata", 32'(bus.RspData), 32'd0);
        chk("rst_err", 32'(bus.ErrFlag), 32'd0);
        chk("rst_addr", 32'(bus.SramAddress), 32'd0);
        chk("rst_indata", 32'(bus.SramInData), 32'd0);
        chk("rst_ce", 32'(bus.SrambCE), 32'd1);
        chk("rst_we", 32'(bus.SrambWE), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
        end
        chk("err_after_good", 32'(bus.ErrFlag), 32'd0);

        // Back-to-back with ReqValid held high.
        wrs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        adrs = '{18'h3FFFF, 18'h00000, 18'h00001, 18'h3FFFF, 18'h00000, 18'h00001};
        dats = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        rsp_q.delete();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.ReqValid = 1'b1;
            bus.ReqWrite = wrs[i];
            bus.ReqAddr  = adrs[i];
            bus.ReqWData = dats[i];
            t = 0;
            while (!bus.ReqReady && t < 50) begin
                @(negedge clk);
                t++;
            end
            acc[i] = cyc + 1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.ReqValid = 1'b0;
        repeat (3 * WS + 12) @(negedge clk);
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("b2b_period%0d", i), acc[i] - acc[i-1],
                WS + 4 + ((wrs[i-1] && CHK) ? WS + 2 : 0));
        end
        chk("b2b_rsp_count", rsp_q.size(), 3);
        if (rsp_q.size() == 3) begin
            chk("b2b_rd_3ffff", 32'(rsp_q[0]), 32'h11);
            chk("b2b_rd_00000", 32'(rsp_q[1]), 32'h22);
            chk("b2b_rd_00001", 32'(rsp_q[2]), 32'h33);
        end

        // Reset asserted mid-ACCESS of a write.
        rsp_q.delete();
        @(negedge clk);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqAddr  = 18'h00020;
        bus.ReqWData = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus.ReqValid = 1'b0;
        t = 0;
        while (bus.SrambWE && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid_rst_reached_access", 32'(bus.SrambWE), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(bus.SrambWE), 32'd1);
        chk("mid_rst_ce", 32'(bus.SrambCE), 32'd1);
        chk("mid_rst_ready", 32'(bus.ReqReady), 32'd1);
        chk("mid_rst_rspvalid", 32'(bus.RspValid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ce_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.SrambCE) ce_hi++;
        end
        chk("post_rst_idle", ce_hi, 10);
        chk("post_rst_no_rsp", rsp_q.size(), 0);

`ifdef SRAM_CTRL_WRCHK_EN
        // Verify read forced to 0x00 against written 0xFF.
        force_bad = 1'b1;
        run_req(1'b1, 18'h00040, 8'hFF, 8'h00, "chk_bad_wr");
        force_bad = 1'b0;
        chk("err_set", 32'(bus.ErrFlag), 32'd1);
        run_req(1'b1, 18'h00041, 8'h3C, 8'h00, "chk_good_wr");
        run_req(1'b0, 18'h00041, 8'h00, 8'h3C, "chk_good_rd");
        chk("err_sticky", 32'(bus.ErrFlag), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("err_cleared", 32'(bus.ErrFlag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        force_bad = 1'b1;
        run_req(1'b1, 18'h00040, 8'hFF, 8'h00, "nochk_wr");
        force_bad = 1'b0;
        chk("err_tied_low", 32'(bus.ErrFlag), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
